// File: rtl/route_alloc.sv
// route_alloc: output-port allocator for a 5-port mesh router node.
// Computes XY routes per input, arbitrates each free output round-robin,
// and holds each connection until the packet tail passes.
module route_alloc #(
    parameter int PORTS   = 5,
    parameter int COORD_W = 4,
    parameter int NODE_X  = 0,
    parameter int NODE_Y  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORTS-1:0]                 req_i,
    input  logic [PORTS-1:0][COORD_W-1:0]    dst_x_i,
    input  logic [PORTS-1:0][COORD_W-1:0]    dst_y_i,
    input  logic [PORTS-1:0]                 tail_i,
    output logic [PORTS-1:0]                 grant_o,
    output logic [PORTS-1:0][PORTS-1:0]      sel_o,
    output logic [PORTS-1:0]                 busy_o
);
    localparam int PW = $clog2(PORTS);

    localparam logic [PW-1:0] P_NORTH = PW'(0);
    localparam logic [PW-1:0] P_SOUTH = PW'(1);
    localparam logic [PW-1:0] P_EAST  = PW'(2);
    localparam logic [PW-1:0] P_WEST  = PW'(3);
    localparam logic [PW-1:0] P_LOCAL = PW'(4);

    typedef enum logic {IDLE = 1'b0, ESTAB = 1'b1} st_t;

    st_t                         st_q  [PORTS];
    st_t                         st_d  [PORTS];
    logic [PW-1:0]               out_q [PORTS];
    logic [PW-1:0]               out_d [PORTS];
    logic [PW-1:0]               ptr_q [PORTS];
    logic [PW-1:0]               ptr_d [PORTS];
    logic [PORTS-1:0][PORTS-1:0] sel_q, sel_d;

    logic [PW-1:0]               route   [PORTS];
    logic [PORTS-1:0]            win_vld;
    logic [PW-1:0]               win_idx [PORTS];

    // Dimension-order route: resolve X first, then Y, else deliver locally.
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            if (dst_x_i[i] > COORD_W'(NODE_X))      route[i] = P_EAST;
            else if (dst_x_i[i] < COORD_W'(NODE_X)) route[i] = P_WEST;
            else if (dst_y_i[i] > COORD_W'(NODE_Y)) route[i] = P_NORTH;
            else if (dst_y_i[i] < COORD_W'(NODE_Y)) route[i] = P_SOUTH;
            else                                    route[i] = P_LOCAL;
        end
    end

    // Per-output round-robin search starting at ptr; only free outputs arbitrate.
    always_comb begin
        logic [PW:0] sum;
        logic [PW-1:0] idx;
        sum = '0;
        idx = '0;
        for (int o = 0; o < PORTS; o++) begin
            win_vld[o] = 1'b0;
            win_idx[o] = '0;
            for (int k = 0; k < PORTS; k++) begin
                sum = {1'b0, ptr_q[o]} + (PW+1)'(k);
                if (sum >= (PW+1)'(PORTS)) sum = sum - (PW+1)'(PORTS);
                idx = sum[PW-1:0];
                if (!win_vld[o] && !(|sel_q[o]) && st_q[idx] == IDLE &&
                    req_i[idx] && route[idx] == PW'(o)) begin
                    win_vld[o] = 1'b1;
                    win_idx[o] = idx;
                end
            end
        end
    end

    // Next state: tails release connections, winners establish new ones.
    // A grant never targets a busy output or an established input, so the
    // two updates never collide.
    always_comb begin
        st_d  = st_q;
        out_d = out_q;
        ptr_d = ptr_q;
        sel_d = sel_q;
        for (int i = 0; i < PORTS; i++) begin
            if (st_q[i] == ESTAB && tail_i[i]) begin
                st_d[i]          = IDLE;
                sel_d[out_q[i]]  = '0;
            end
        end
        for (int o = 0; o < PORTS; o++) begin
            if (win_vld[o]) begin
                st_d[win_idx[o]]  = ESTAB;
                out_d[win_idx[o]] = PW'(o);
                sel_d[o]          = PORTS'(1) << win_idx[o];
                ptr_d[o]          = (win_idx[o] == PW'(PORTS-1)) ? '0 : win_idx[o] + PW'(1);
            end
        end
    end

    // State registers; reset drops any held connection.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PORTS; i++) begin
                st_q[i]  <= IDLE;
                out_q[i] <= '0;
                ptr_q[i] <= '0;
            end
            sel_q <= '0;
        end else begin
            st_q  <= st_d;
            out_q <= out_d;
            ptr_q <= ptr_d;
            sel_q <= sel_d;
        end
    end

    // Outputs follow the registered connection state directly.
    always_comb begin
        grant_o = '0;
        busy_o  = '0;
        sel_o   = sel_q;
        for (int i = 0; i < PORTS; i++) begin
            grant_o[i] = (st_q[i] == ESTAB);
            busy_o[i]  = |sel_q[i];
        end
    end
endmodule

// File: doc/route_alloc.md
# route_alloc

Output-port allocator and connection controller for the 5-port mesh router node (N, S, E, W, Local). It takes per-input header requests carrying destination coordinates and computes dimension-order (XY) routes. It arbitrates each output round-robin among competing inputs and holds the granted connection until the packet tail passes. It drives the crossbar select matrix and the per-input ack.

## Interface
- PORTS, 5, fixed port encoding NORTH=0, SOUTH=1, EAST=2, WEST=3, LOCAL=4
- COORD_W, 4, width of each destination coordinate
- NODE_X, 0, this node's X coordinate (unsigned, COORD_W bits)
- NODE_Y, 0, this node's Y coordinate (unsigned, COORD_W bits)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- req_i  input  [PORTS]  input i presents a header flit
- dst_x_i  input  [PORTS][COORD_W]  destination X of input i's header, valid with req_i[i]
- dst_y_i  input  [PORTS][COORD_W]  destination Y of input i's header, valid with req_i[i]
- tail_i  input  [PORTS]  last flit of input i's packet transferred this cycle
- grant_o  output  [PORTS]  input i has an established connection (crossbar ack)
- sel_o  output  [PORTS][PORTS]  sel_o[o] is a one-hot input index driving output o, or all-zero when free
- busy_o  output  [PORTS]  output o allocated

## Operation
- Route (combinational, per input), unsigned compares, Y increasing northward:
  - dst_x > NODE_X: EAST
  - dst_x < NODE_X: WEST
  - dst_x equal and dst_y > NODE_Y: NORTH
  - dst_x equal and dst_y < NODE_Y: SOUTH
  - both equal: LOCAL
- Per-input FSM:
  - IDLE to ESTABLISHED when granted.
  - ESTABLISHED to IDLE when tail_i[i] is sampled high.
- Registered route per input: out_r[i], captured at grant.
- Candidates for output o: inputs in IDLE with req_i high and route == o. An output is arbitrated only when busy_o[o]=0.
- Arbitration: per-output round-robin pointer ptr[o]. Search inputs ptr[o], ptr[o]+1, … modulo PORTS; the first candidate wins.
- After a grant to input g, ptr[o] <= (g+1) mod PORTS. The pointer is unchanged when there is no grant.
- The five outputs arbitrate independently and in parallel. Multiple grants in one cycle are allowed when they target different outputs.
- Grant effects at the edge:
  - grant_o[g] <= 1
  - sel_o[o] <= onehot(g)
  - busy_o[o] <= 1
  - out_r[g] <= o
- Release effects at the edge where tail_i[i] is sampled in ESTABLISHED:
  - grant_o[i] <= 0
  - sel_o[out_r[i]] <= 0
  - busy_o[out_r[i]] <= 0
- Ignored inputs:
  - req_i and dst_*_i while the input is ESTABLISHED.
  - tail_i while the input is IDLE.
- U-turn routes (route == arrival port) are not filtered; they are granted like any other route.
- Invariants (bench asserts every cycle):
  - each sel_o[o] is zero or one-hot;
  - no input index appears in more than one sel_o;
  - busy_o[o] == |sel_o[o];
  - grant_o[i] is high exactly when input i appears in some sel_o.

## Timing
- Reset: on the edge with rst=1, regardless of state:
  - grant_o=0, sel_o=0, busy_o=0
  - all FSMs IDLE, all ptr=0, out_r=0
  - connections held mid-packet are dropped.
- Grant latency: req_i sampled at edge k with a free output and winning arbitration gives grant_o high after edge k, visible in cycle k+1.
- A losing requester keeps req_i asserted. It is re-evaluated every cycle and has no timeout.
- Release latency: tail_i sampled at edge k drops grant_o/sel_o/busy_o after edge k.
- A freed output is arbitrated in cycle k+1 and the new grant appears after edge k+1. The minimum gap on an output between tail and the next owner is one cycle.
- Single-flit packet: tail_i may assert in the first ESTABLISHED cycle (the cycle after grant).
- Same-input tail and req in one ESTABLISHED cycle: the tail releases and req is ignored. A new header must be held and is arbitrated next cycle from IDLE.
- rst has priority over all simultaneous grant and release events.

## Test plan
- Reset then single request: NODE=(1,1), req_i[LOCAL]=1, dst=(3,1).
  - Cycle+1: grant_o=5'b10000, sel_o[EAST]=5'b10000, busy_o[EAST]=1.
  - tail_i[4] one cycle later clears all of these next cycle.
- XY routing sweep: NODE=(1,1), dst (0,5), (2,0), (1,2), (1,0), (1,1) on input NORTH give outputs WEST, EAST, NORTH, SOUTH, LOCAL respectively.
- Round-robin contention: inputs 0, 2, 3 request EAST continuously, each releasing one cycle after grant. Required grant order 0, 2, 3, 0, with ptr[EAST] = 1, 3, 4, 1.
- Parallel grants: input N to EAST and input W to LOCAL in the same cycle. Both grant_o bits rise on the same edge; sel_o[EAST]=5'b00001, sel_o[LOCAL]=5'b01000.
- Reset mid-packet: two connections established, then rst=1 for one cycle with tail_i and req_i active. All outputs are zero after that edge and ptr=0. The first request after rst deasserts is granted per ptr=0 order.
